avsdsar_ctrl: RTL and testbench
===============================

// Module: avsdsar_ctrl
// PURPOSE
//   Successive-approximation ADC controller: the capture direction of the core-to-DAC path.
//   Drives the trial code of a resistor-string DAC and reads back an external analog comparator.
//   Produces a WIDTH-bit conversion result for the rvmyth core.
//   Clocked from the PLL output clock in the mini-SoC.
// PARAMETERS
//   WIDTH         10  resolution; width of DAC_D and DATA
//   SAMPLE_CYCLES 4   cycles SAMPLE is held high (track phase), >=1
//   SETTLE_CYCLES 3   cycles per bit trial (DAC settle + CMP sync), >= SYNC_STAGES+1
//   SYNC_STAGES   2   flops in the CMP synchroniser, >=2
// PORTS
//   CLK     in   1      system clock (PLL output)
//   reset   in   1      asynchronous, active-high reset
//   start   in   1      conversion request, level-sampled in IDLE
//   CMP     in   1      async comparator output; 1 = VIN >= DAC(DAC_D)
//   DAC_D   out  WIDTH  trial code to the DAC
//   SAMPLE  out  1      track/hold switch enable, high during the track phase
//   busy    out  1      high from SAMPLE entry through the last trial
//   done    out  1      one-cycle pulse; DATA is updated on the same edge
//   DATA    out  WIDTH  last completed result, held until the next done
//   CONT    in   1      continuous-mode enable (present only with SAR_CONT_EN)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; DAC_D=0, SAMPLE=0, busy=0, done=0, DATA=0; sync flops=0.
//   FSM states: IDLE -> SAMPLE -> TRIAL (x WIDTH bits) -> DONE -> IDLE.
//   IDLE: DAC_D=0. If start=1 at an edge, enter SAMPLE.
//   SAMPLE: SAMPLE=1, busy=1, DAC_D=0 for SAMPLE_CYCLES cycles.
//     Then clear the working register and set bit index i=WIDTH-1.
//   TRIAL bit i: DAC_D = work | (1<<i) for SETTLE_CYCLES cycles; busy=1.
//     On the edge ending the trial, bit i of work = synchronised CMP. Then i=i-1.
//     After bit 0 is resolved, go to DONE.
//   DONE (1 cycle): DATA<=work, done=1, busy=0, DAC_D=0. Next state is IDLE.
//   Latency: start sampled at edge k -> done high after edge k+1+SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES.
//     With defaults, done rises at edge k+35.
//   Back-to-back: start held high -> one done every SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES+2 cycles (36).
//   start while busy or in DONE: ignored; no queueing.
//   CMP is used only through the SYNC_STAGES synchroniser, never raw.
//   Bit counter and settle counter are sized for their parameters; no wrap occurs within one conversion.
//   Reset mid-conversion: aborts immediately. DATA is cleared (not the partial result); no done pulse.
//   Work-register bits below i stay 0 during trials, so DAC_D is monotonic in the trial history.
// CONFIGURATION
//   SAR_CONT_EN defined:
//     CONT port exists.
//     In DONE, if CONT=1, go directly to SAMPLE instead of IDLE; period becomes 35 cycles (defaults).
//     CONT=0 behaves as without the macro.
//     busy drops for the DONE cycle only.
//   SAR_CONT_EN undefined:
//     No CONT port.
//     Each conversion needs start to be sampled in IDLE.
// TESTING
//   1. Comparator model, VIN code 677 (0x2A5); start pulse at edge 0
//      -> done at edge 35, DATA=0x2A5.
//      DAC_D trial sequence starts 0x200, 0x300, 0x280...
//   2. VIN code 0 -> DATA=0x000.
//      VIN code 1023 -> DATA=0x3FF.
//      Check CMP resolves correctly at both code endpoints.
//   3. Extra start pulses at edges 10 and 34 -> exactly one done, at edge 35.
//      busy stays high 1..34.
//   4. reset asserted during trial of bit 5, then released
//      -> outputs 0 immediately, no done.
//      A fresh start yields the correct result 35 cycles later.
//   5. start held high, VIN=0x155
//      -> done every 36 cycles, DATA=0x155 each time.
//      SAMPLE high for 4 cycles per conversion.
//   6. SAR_CONT_EN, CONT=1, single start
//      -> done every 35 cycles.
//      CONT=0 mid-stream -> stops after the current done.

Source files
------------

// File: rtl/avsdsar_ctrl.sv
// Successive-approximation ADC controller: drives a resistor-string DAC trial code and
// resolves one bit per trial from a synchronised comparator. Optional `SAR_CONT_EN adds CONT.
module avsdsar_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             CMP,
  output logic [WIDTH-1:0] DAC_D,
  output logic             SAMPLE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DATA
`ifdef SAR_CONT_EN
  ,
  input  logic             CONT
`endif
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOP = ONE << (WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_TRIAL, S_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIT_W-1:0]   bit_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   dac_q;
  logic [WIDTH-1:0]   data_q;
  logic               sample_q;
  logic               busy_q;
  logic               done_q;
  logic [SYNC_STAGES-1:0] sync_q;

  logic               cmp_s;
  logic               cont_w;
  logic [WIDTH-1:0]   work_d;
  logic [BIT_W-1:0]   bit_d;

`ifdef SAR_CONT_EN
  assign cont_w = CONT;
`else
  assign cont_w = 1'b0;
`endif

  // Comparator is asynchronous to CLK; only the last synchroniser stage is ever used.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], CMP};
  end
  assign cmp_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    work_d        = work_q;
    work_d[bit_q] = cmp_s;
    bit_d         = bit_q - BIT_W'(1);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      work_q   <= '0;
      dac_q    <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dac_q <= '0;
          if (start) begin
            state_q  <= S_SAMPLE;
            cnt_q    <= '0;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == CNT_W'(SAMPLE_CYCLES-1)) begin
            state_q  <= S_TRIAL;
            cnt_q    <= '0;
            sample_q <= 1'b0;
            work_q   <= '0;
            bit_q    <= BIT_W'(WIDTH-1);
            dac_q    <= TOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_TRIAL: begin
          // Lower bits of work are still 0 here, so the next trial only adds one bit.
          if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) begin
            cnt_q  <= '0;
            work_q <= work_d;
            if (bit_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              dac_q   <= '0;
            end else begin
              bit_q <= bit_d;
              dac_q <= work_d | (ONE << bit_d);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          data_q <= work_q;
          done_q <= 1'b1;
          dac_q  <= '0;
          if (cont_w) begin
            state_q  <= S_SAMPLE;
            cnt_q    <= '0;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DAC_D  = dac_q;
  assign SAMPLE = sample_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign DATA   = data_q;

endmodule

// File: tb/tb_avsdsar_ctrl.sv
// Self-checking bench for avsdsar_ctrl: ideal comparator, random and edge-case VIN codes,
// timing of done/busy/SAMPLE, mid-conversion reset, back-to-back and continuous modes.
module tb_avsdsar_ctrl;
  localparam int W = 10;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         cmp;
  logic         cont = 1'b0;
  logic [W-1:0] DAC_D;
  logic         SAMPLE;
  logic         busy;
  logic         done;
  logic [W-1:0] DATA;
  int           vin = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  // Ideal comparator: 1 when the input voltage is at or above the DAC level.
  assign cmp = (vin >= int'(DAC_D));

  avsdsar_ctrl dut (
    .CLK    (CLK),
    .reset  (reset),
    .start  (start),
    .CMP    (cmp),
    .DAC_D  (DAC_D),
    .SAMPLE (SAMPLE),
    .busy   (busy),
    .done   (done),
    .DATA   (DATA)
`ifdef SAR_CONT_EN
    ,
    .CONT   (cont)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Binary search trial n (0 = MSB) keeps the already-decided upper bits of v and tests the next one.
  function automatic int trial_code(input int v, input int n);
    int keep;
    keep = (v >> (W - n)) << (W - n);
    return keep | (1 << (W - 1 - n));
  endfunction

  // One conversion with start sampled at edge k; c counts cycles after edge k.
  task automatic conv(input int v, input int xs1, input int xs2, input bit full);
    int done_at;
    int ndone;
    int busy_n;
    int samp_n;
    vin = v;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    done_at = -1; ndone = 0; busy_n = 0; samp_n = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge CLK);
      start = ((c + 1) == xs1) || ((c + 1) == xs2);
      if (SAMPLE) samp_n++;
      if (busy) busy_n++;
      if (full && c >= 4 && c < 34 && ((c - 4) % 3) == 0)
        check("trial_code", int'(DAC_D), trial_code(v, (c - 4) / 3));
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = c;
          check("data", int'(DATA), v);
        end
      end
    end
    start = 1'b0;
    check("done_edge", done_at, 35);
    check("done_count", ndone, 1);
    check("busy_cycles", busy_n, 34);
    check("sample_cycles", samp_n, 4);
    check("data_held", int'(DATA), v);
  endtask

  initial begin
    int ndone;
    int samp_n;
    int dones[$];

    #2 reset = 1'b1;
    #1;
    check("rst_dac", int'(DAC_D), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sample", int'(SAMPLE), 0);
    check("rst_done", int'(done), 0);
    check("rst_data", int'(DATA), 0);
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    // Known code with full trial-sequence check, then both endpoints.
    conv(677, -1, -1, 1'b1);
    conv(0, -1, -1, 1'b1);
    conv(1023, -1, -1, 1'b1);

    // Extra start pulses while busy and on the final trial edge are ignored.
    conv(321, 10, 34, 1'b0);

    for (int r = 0; r < 6; r++) conv(int'($urandom_range(0, 1023)), -1, -1, 1'b1);

    // Reset during the bit-5 trial aborts and clears everything.
    vin = 'h3C3;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0;
    repeat (17) @(negedge CLK);
    reset = 1'b1;
    #1;
    check("abort_dac", int'(DAC_D), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_sample", int'(SAMPLE), 0);
    check("abort_data", int'(DATA), 0);
    check("abort_done", int'(done), 0);
    @(negedge CLK); reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    conv('h3C3, -1, -1, 1'b1);

    // start held high: one conversion every 36 cycles.
    vin = 'h155;
    dones.delete();
    samp_n = 0;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    for (int c = 0; c < 108; c++) begin
      @(negedge CLK);
      if (c == 107) start = 1'b0;
      if (SAMPLE) samp_n++;
      if (done) begin
        dones.push_back(c);
        check("b2b_data", int'(DATA), 'h155);
      end
    end
    check("b2b_count", dones.size(), 3);
    check("b2b_sample", samp_n, 12);
    for (int j = 0; j < dones.size() && j < 3; j++) check("b2b_done_edge", dones[j], 35 + 36 * j);
    repeat (40) @(negedge CLK);

`ifdef SAR_CONT_EN
    // Continuous mode: a single start, then one result every 35 cycles until CONT drops.
    vin = 'h2A5;
    dones.delete();
    cont = 1'b1;
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    for (int c = 0; c < 150; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (c == 80) cont = 1'b0;
      if (done) begin
        dones.push_back(c);
        check("cont_data", int'(DATA), 'h2A5);
      end
    end
    check("cont_count", dones.size(), 3);
    for (int j = 0; j < dones.size() && j < 3; j++) check("cont_done_edge", dones[j], 35 + 35 * j);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
